// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: clk_out = clk_in / N for 2 <= N <= 2^DIV_W-1,
// with shadowed divisor updates and stop requests that take effect only at period boundaries.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_e           state_q,   state_d;
    logic [DIV_W-1:0] cnt_q,     cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] shadow_q,  shadow_d;
    logic             pend_q,    pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;
    logic             div_ack_q, div_ack_d;
    logic             div_err_q, div_err_d;

    logic load_ok;
    logic load_bad;
    logic at_bnd;

    // High phase length ceil(n/2); one extra bit so n = 2^DIV_W-1 does not overflow.
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n);
        logic [DIV_W:0] sum;
        sum = {1'b0, n} + {{DIV_W{1'b0}}, 1'b1};
        return sum[DIV_W:1];
    endfunction

    assign load_ok  = div_load && (div_val >= DIV_MIN);
    assign load_bad = div_load && (div_val <  DIV_MIN);
    assign at_bnd   = (state_q != ST_IDLE) && (cnt_q == (cur_div_q - ONE));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        div_ack_d = 1'b0;
        div_err_d = load_bad;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (load_ok) begin
                    cur_div_d = div_val;
                    div_ack_d = 1'b1;
                end
                // First cycle of a period is always high since ceil(N/2) >= 1.
                if (en) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end

            ST_RUN, ST_STOP: begin
                if (at_bnd) begin
                    // A load in the boundary cycle beats the older shadowed value.
                    if (load_ok) begin
                        cur_div_d = div_val;
                        div_ack_d = 1'b1;
                        pend_d    = 1'b0;
                    end else if (pend_q) begin
                        cur_div_d = shadow_q;
                        div_ack_d = 1'b1;
                        pend_d    = 1'b0;
                    end
                    cnt_d = '0;
                    if (en) begin
                        state_d   = ST_RUN;
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_q + ONE;
                    clk_out_d = (cnt_d < high_len(cur_div_q));
                    if (load_ok) begin
                        shadow_d = div_val;
                        pend_d   = 1'b1;
                    end
                    if ((state_q == ST_RUN) && !en) begin
                        state_d = ST_STOP;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_div_q <= DIV_RST;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            div_ack_q <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            div_ack_q <= div_ack_d;
            div_err_q <= div_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_ack = div_ack_q;
    assign div_err = div_err_q;
    assign busy    = pend_q;
    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a waveform-level reference model queues expected
// outputs per cycle, and a monitor compares them against the DUT after each edge.
module tb_clk_div_prog;

    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;

    typedef struct packed {
        logic             clk_out;
        logic             tick;
        logic             div_ack;
        logic             div_err;
        logic             busy;
        logic [DIV_W-1:0] cur_div;
    } obs_t;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [DIV_W-1:0] cur_div;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: each period is expanded into a list of {high, tick} samples.
    logic [1:0]       wave[$];
    bit               m_run;
    bit               m_pend;
    logic [DIV_W-1:0] m_cur;
    logic [DIV_W-1:0] m_shadow;
    bit               cur_en;

    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .div_ack (div_ack),
        .div_err (div_err),
        .busy    (busy),
        .cur_div (cur_div)
    );

    always #5 clk_in = ~clk_in;

    function automatic void start_period(input int n);
        int h;
        h = (n + 1) / 2;
        for (int i = 0; i < n; i++) begin
            wave.push_back({(i < h), (i == 0)});
        end
        m_run = 1'b1;
    endfunction

    // Expected outputs after the coming edge, given the inputs held during this cycle.
    function automatic obs_t model_step(input bit r, input bit e, input bit ld,
                                        input logic [DIV_W-1:0] v);
        obs_t       o;
        logic [1:0] s;
        bit         ok;
        bit         ack;
        ok  = ld && (int'(v) >= 2);
        ack = 1'b0;
        s   = 2'b00;
        if (!r) begin
            m_run    = 1'b0;
            m_pend   = 1'b0;
            m_cur    = DIV_W'(DEFAULT_DIV);
            m_shadow = '0;
            wave.delete();
            o         = '0;
            o.cur_div = DIV_W'(DEFAULT_DIV);
            return o;
        end
        if (!m_run) begin
            if (ok) begin
                m_cur = v;
                ack   = 1'b1;
            end
            if (e) start_period(int'(m_cur));
        end else if (wave.size() == 0) begin
            if (ok) begin
                m_cur  = v;
                ack    = 1'b1;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_cur  = m_shadow;
                ack    = 1'b1;
                m_pend = 1'b0;
            end
            if (e) start_period(int'(m_cur));
            else   m_run = 1'b0;
        end else if (ok) begin
            m_shadow = v;
            m_pend   = 1'b1;
        end
        if (wave.size() > 0) s = wave.pop_front();
        o.clk_out = s[1];
        o.tick    = s[0];
        o.div_ack = ack;
        o.div_err = ld && (int'(v) < 2);
        o.busy    = m_pend;
        o.cur_div = m_cur;
        return o;
    endfunction

    task automatic step(input bit r, input bit e, input bit ld, input logic [DIV_W-1:0] v);
        @(negedge clk_in);
        rst_n    = r;
        en       = e;
        div_load = ld;
        div_val  = v;
        exp_q.push_back(model_step(r, e, ld, v));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, cur_en, 1'b0, '0);
    endtask

    task automatic load(input logic [DIV_W-1:0] v);
        step(1'b1, cur_en, 1'b1, v);
    endtask

    task automatic set_en(input bit e);
        cur_en = e;
    endtask

    // Monitor: one queued expectation per edge once stimulus has started.
    initial begin
        obs_t e_v;
        obs_t a_v;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e_v = exp_q.pop_front();
                a_v = {clk_out, tick, div_ack, div_err, busy, cur_div};
                n_vec++;
                if (a_v !== e_v) begin
                    n_bad++;
                    $display("FAIL vec %0d @%0t: got clk_out=%b tick=%b ack=%b err=%b busy=%b cur_div=%0d, expected clk_out=%b tick=%b ack=%b err=%b busy=%b cur_div=%0d",
                             n_vec, $time, a_v.clk_out, a_v.tick, a_v.div_ack, a_v.div_err,
                             a_v.busy, a_v.cur_div, e_v.clk_out, e_v.tick, e_v.div_ack,
                             e_v.div_err, e_v.busy, e_v.cur_div);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        cur_en   = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
        idle_steps(2);

        // N=2 run straight out of reset, then stop.
        set_en(1'b1); idle_steps(8);
        set_en(1'b0); idle_steps(6);

        // Load 5 in IDLE, then run.
        load(8'd5); idle_steps(2);
        set_en(1'b1); idle_steps(12);

        // Switch to 4, then load 7 mid-period.
        load(8'd4); idle_steps(12);
        idle_steps(1);
        load(8'd7); idle_steps(20);

        // At N=6, load 3 then 9 before the boundary.
        load(8'd6); idle_steps(14);
        load(8'd3); idle_steps(1);
        load(8'd9); idle_steps(20);

        // Rejected loads.
        load(8'd1); idle_steps(1);
        load(8'd0); idle_steps(10);

        // N=8: drop en mid-period, restart, then reset mid-period.
        load(8'd8); idle_steps(20);
        set_en(1'b0); idle_steps(14);
        set_en(1'b1); idle_steps(10);
        step(1'b0, 1'b1, 1'b0, '0);
        idle_steps(5);

        // Load landing exactly in the boundary cycle of a 5-cycle period started from IDLE.
        set_en(1'b0); idle_steps(4);
        load(8'd5); idle_steps(1);
        set_en(1'b1); idle_steps(5);
        load(8'd3); idle_steps(8);

        // Pending divisor applied at a boundary that enters IDLE.
        load(8'd6); idle_steps(8);
        load(8'd4);
        set_en(1'b0); idle_steps(10);

        // Randomised traffic.
        set_en(1'b1);
        for (int i = 0; i < 3000; i++) begin
            bit               r;
            bit               ld;
            logic [DIV_W-1:0] v;
            if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
            r  = ($urandom_range(0, 399) != 0);
            ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) v = DIV_W'($urandom_range(200, 255));
            else                            v = DIV_W'($urandom_range(0, 12));
            step(r, cur_en, ld, v);
        end
        set_en(1'b0); idle_steps(300);

        @(posedge clk_in);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
